// File: rtl/wb_drain_ctrl.sv
// Write-back buffer drain sequencer: issues the head entry as one or two
// word-aligned beats to the D-cache or memory port, then pops it.
module wb_drain_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_empty,
  input  logic        wb_en_vld,
  input  logic        wb_en_cach,
  input  logic [14:0] wb_en_addr,
  input  logic [31:0] wb_en_data,
  input  logic [2:0]  wb_en_size,
  output logic        wb_read,
  input  logic        hold,
  output logic        drain_idle,
  output logic        dc_req,
  output logic [14:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_be,
  input  logic        dc_ack,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, POP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state;
  logic        cach_q;
  logic        split_q;
  logic [14:0] addr1_q;
  logic [31:0] wdata1_q;
  logic [3:0]  be1_q;
  logic [7:0]  tcnt;

  logic [1:0]  off;
  logic        size_bad;
  logic [2:0]  sz;
  logic [3:0]  m;
  logic        split;
  logic [7:0]  be_w;
  logic [63:0] data_w;
  logic [14:0] addr0;
  logic        start;
  logic        ack;
  logic        idle_next;

  // Both beats are computed up front: the 64-bit/8-bit shifted images hold
  // beat0 in the low word/nibble and the spill-over beat1 in the high half.
  always_comb begin
    off      = wb_en_addr[1:0];
    size_bad = !(wb_en_size inside {3'd1, 3'd2, 3'd4});
    sz       = size_bad ? 3'd4 : wb_en_size;
    case (sz)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    split     = ({2'b00, off} + {1'b0, sz}) > 4'd4;
    be_w      = {4'b0000, m} << off;
    data_w    = {32'h0, wb_en_data} << {off, 3'b000};
    addr0     = {wb_en_addr[14:2], 2'b00};
    start     = (state == IDLE) && wb_en_vld && !wb_empty && !hold;
    ack       = cach_q ? dc_ack : mem_ack;
    idle_next = ((state == IDLE) && !start) || (state == POP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cach_q     <= 1'b0;
      split_q    <= 1'b0;
      addr1_q    <= '0;
      wdata1_q   <= '0;
      be1_q      <= '0;
      tcnt       <= '0;
      wb_read    <= 1'b0;
      drain_idle <= 1'b0;
      dc_req     <= 1'b0;
      dc_addr    <= '0;
      dc_wdata   <= '0;
      dc_be      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      err        <= 1'b0;
    end else begin
      drain_idle <= wb_empty && idle_next;
      case (state)
        IDLE: begin
          wb_read <= 1'b0;
          if (start) begin
            cach_q   <= wb_en_cach;
            split_q  <= split;
            addr1_q  <= addr0 + 15'd4;
            wdata1_q <= data_w[63:32];
            be1_q    <= be_w[7:4];
            tcnt     <= '0;
            if (size_bad) err <= 1'b1;
            if (wb_en_cach) begin
              dc_req   <= 1'b1;
              dc_addr  <= addr0;
              dc_wdata <= data_w[31:0];
              dc_be    <= be_w[3:0];
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= addr0;
              mem_wdata <= data_w[31:0];
              mem_be    <= be_w[3:0];
            end
            state <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          if (ack) begin
            tcnt <= '0;
            if (state == BEAT0 && split_q) begin
              if (cach_q) begin
                dc_addr  <= addr1_q;
                dc_wdata <= wdata1_q;
                dc_be    <= be1_q;
              end else begin
                mem_addr  <= addr1_q;
                mem_wdata <= wdata1_q;
                mem_be    <= be1_q;
              end
              state <= BEAT1;
            end else begin
              dc_req  <= 1'b0;
              mem_req <= 1'b0;
              wb_read <= 1'b1;
              state   <= POP;
            end
          end else if (tcnt != TMO) begin
            // Saturates at TMO; the beat keeps waiting, only the flag is raised.
            tcnt <= tcnt + 8'd1;
            if (tcnt + 8'd1 == TMO) err <= 1'b1;
          end
        end
        POP: begin
          wb_read <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Scoreboard bench for wb_drain_ctrl: a FIFO model feeds the head, expected
// beats/pops are queued by the stimulus and consumed by a monitor.
module tb_wb_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_empty;
  logic        wb_en_vld;
  logic        wb_en_cach;
  logic [14:0] wb_en_addr;
  logic [31:0] wb_en_data;
  logic [2:0]  wb_en_size;
  logic        wb_read;
  logic        hold;
  logic        drain_idle;
  logic        dc_req;
  logic [14:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_be;
  logic        dc_ack;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        err;

  wb_drain_ctrl #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .wb_empty(wb_empty), .wb_en_vld(wb_en_vld),
    .wb_en_cach(wb_en_cach), .wb_en_addr(wb_en_addr), .wb_en_data(wb_en_data),
    .wb_en_size(wb_en_size), .wb_read(wb_read), .hold(hold), .drain_idle(drain_idle),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be), .dc_ack(dc_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cach;
    logic [14:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } entry_t;

  typedef struct {
    logic        port;   // 0 = dc, 1 = mem
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  entry_t bufq[$];
  beat_t  exp_beats[$];
  int     exp_pops[$];

  int checks = 0;
  int errors = 0;

  bit          ack_en;
  int unsigned ack_delay;
  bit          stray_dc;
  bit          mem_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_buf(input logic c, input logic [14:0] a, input logic [2:0] s,
                          input logic [31:0] d);
    entry_t e;
    e.cach = c; e.addr = a; e.size = s; e.data = d;
    bufq.push_back(e);
  endtask

  task automatic exp_beat(input logic p, input logic [14:0] a, input logic [31:0] w,
                          input logic [3:0] b);
    beat_t x;
    x.port = p; x.addr = a; x.wdata = w; x.be = b;
    exp_beats.push_back(x);
  endtask

  task automatic wait_req(input int unsigned budget, input string name);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = dc_req | mem_req;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_pop(input int unsigned budget, input string name);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = wb_read;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input int unsigned budget, input string name);
    bit done = 1'b0;
    for (int unsigned i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (bufq.size() == 0) && (exp_pops.size() == 0) && drain_idle;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // Buffer model: pop on the edge that samples wb_read, present the new head after it.
  initial begin
    bit pop_now;
    wb_empty = 1'b1; wb_en_vld = 1'b0; wb_en_cach = 1'b0;
    wb_en_addr = '0; wb_en_data = '0; wb_en_size = '0;
    forever begin
      @(negedge clk);
      pop_now = wb_read && !rst;
      @(posedge clk);
      #1;
      if (pop_now && bufq.size() > 0) void'(bufq.pop_front());
      if (bufq.size() > 0) begin
        wb_empty   = 1'b0;
        wb_en_vld  = 1'b1;
        wb_en_cach = bufq[0].cach;
        wb_en_addr = bufq[0].addr;
        wb_en_data = bufq[0].data;
        wb_en_size = bufq[0].size;
      end else begin
        wb_empty  = 1'b1;
        wb_en_vld = 1'b0;
      end
    end
  end

  // Ack responder: acks a beat after ack_delay waiting cycles.
  initial begin
    int unsigned wait_cnt = 0;
    bit acked;
    dc_ack = 1'b0; mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      acked   = dc_ack | mem_ack;
      dc_ack  = stray_dc;
      mem_ack = 1'b0;
      if (acked) wait_cnt = 0;
      if (dc_req | mem_req) begin
        if (ack_en && wait_cnt >= ack_delay) begin
          dc_ack  = dc_req | stray_dc;
          mem_ack = mem_req;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: checks beats at handshake, stability while waiting, and pops.
  initial begin
    int    beats_seen = 0;
    bit    prev_wait = 1'b0;
    bit    prev_read = 1'b0;
    beat_t prev, cur, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats_seen = 0; prev_wait = 1'b0; prev_read = 1'b0;
      end else begin
        if (mem_req) mem_seen = 1'b1;
        if (dc_req && mem_req) chk("both_req", 64'd1, 64'd0);
        cur.port  = mem_req;
        cur.addr  = mem_req ? mem_addr  : dc_addr;
        cur.wdata = mem_req ? mem_wdata : dc_wdata;
        cur.be    = mem_req ? mem_be    : dc_be;
        if (prev_wait && (dc_req || mem_req))
          chk("req_stable", {12'h0, cur.port, cur.addr, cur.wdata, cur.be},
                            {12'h0, prev.port, prev.addr, prev.wdata, prev.be});
        if ((dc_req && dc_ack) || (mem_req && mem_ack)) begin
          if (exp_beats.size() == 0) begin
            chk("unexpected_beat", {12'h0, cur.port, cur.addr, cur.wdata, cur.be}, 64'd0);
          end else begin
            e = exp_beats.pop_front();
            chk("beat", {12'h0, cur.port, cur.addr, cur.wdata, cur.be},
                        {12'h0, e.port, e.addr, e.wdata, e.be});
          end
          beats_seen++;
          prev_wait = 1'b0;
        end else begin
          prev_wait = dc_req || mem_req;
          prev = cur;
        end
        if (wb_read) begin
          chk("pop_single_cycle", 64'(prev_read), 64'd0);
          if (exp_pops.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
          else chk("pop_beats", 64'(beats_seen), 64'(exp_pops.pop_front()));
          beats_seen = 0;
        end
        prev_read = wb_read;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any;
    rst = 1'b1; hold = 1'b0; ack_en = 1'b1; ack_delay = 0; stray_dc = 1'b0; mem_seen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {60'h0, dc_req, mem_req, wb_read, err}, 64'd0);
    chk("rst_addr_be", {26'h0, dc_be, mem_be, dc_addr, mem_addr}, 64'd0);
    chk("rst_wdata", {dc_wdata, mem_wdata}, 64'd0);
    rst = 1'b0;

    // single cachable word, ack on first request cycle
    mem_seen = 1'b0;
    push_buf(1'b1, 15'h0100, 3'd4, 32'hDEADBEEF); exp_pops.push_back(1);
    exp_beat(1'b0, 15'h0100, 32'hDEADBEEF, 4'b1111);
    wait_drain(40, "t1_drain");
    chk("t1_no_mem_req", 64'(mem_seen), 64'd0);

    // uncachable halfword crossing a word boundary
    push_buf(1'b0, 15'h0103, 3'd2, 32'h0000ABCD); exp_pops.push_back(2);
    exp_beat(1'b1, 15'h0100, 32'hCD000000, 4'b1000);
    exp_beat(1'b1, 15'h0104, 32'h000000AB, 4'b0001);
    wait_drain(40, "t2_drain");

    // four entries, delayed acks, last one splits and wraps the address space
    ack_delay = 3;
    push_buf(1'b1, 15'h0200, 3'd1, 32'h00000011); exp_pops.push_back(1);
    exp_beat(1'b0, 15'h0200, 32'h00000011, 4'b0001);
    push_buf(1'b1, 15'h0205, 3'd1, 32'h00000022); exp_pops.push_back(1);
    exp_beat(1'b0, 15'h0204, 32'h00002200, 4'b0010);
    push_buf(1'b0, 15'h020A, 3'd2, 32'h00003344); exp_pops.push_back(1);
    exp_beat(1'b1, 15'h0208, 32'h33440000, 4'b1100);
    push_buf(1'b1, 15'h7FFE, 3'd4, 32'h55667788); exp_pops.push_back(2);
    exp_beat(1'b0, 15'h7FFC, 32'h77880000, 4'b1100);
    exp_beat(1'b0, 15'h0000, 32'h00005566, 4'b0011);
    wait_drain(150, "t3_drain");

    // hold blocks new entries but not the in-flight one
    hold = 1'b1;
    push_buf(1'b1, 15'h0010, 3'd4, 32'hCAFEF00D); exp_pops.push_back(1);
    exp_beat(1'b0, 15'h0010, 32'hCAFEF00D, 4'b1111);
    push_buf(1'b0, 15'h0011, 3'd4, 32'h01234567); exp_pops.push_back(2);
    exp_beat(1'b1, 15'h0010, 32'h23456700, 4'b1110);
    exp_beat(1'b1, 15'h0014, 32'h00000001, 4'b0001);
    any = 1'b0;
    repeat (10) begin @(negedge clk); any |= dc_req | mem_req; end
    chk("t4_hold_noreq", 64'(any), 64'd0);
    chk("t4_hold_not_idle", 64'(drain_idle), 64'd0);
    ack_delay = 5;
    hold = 1'b0;
    wait_req(20, "t4_req");
    hold = 1'b1;
    wait_pop(30, "t4_inflight_pop");
    any = 1'b0;
    repeat (8) begin @(negedge clk); any |= dc_req | mem_req; end
    chk("t4_next_held", 64'(any), 64'd0);
    chk("t4_pending", 64'(exp_pops.size()), 64'd1);
    hold = 1'b0;
    wait_drain(60, "t4_drain");

    // illegal size flags err and writes a full word
    ack_delay = 0;
    push_buf(1'b1, 15'h0020, 3'd5, 32'h89ABCDEF); exp_pops.push_back(1);
    exp_beat(1'b0, 15'h0020, 32'h89ABCDEF, 4'b1111);
    wait_req(20, "t5_req");
    chk("t5_err_size", 64'(err), 64'd1);
    wait_drain(40, "t5_drain");
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_clears_err", 64'(err), 64'd0);
    rst = 1'b0;

    // ack timeout: err at exactly 255 waiting cycles, request stays up
    ack_en = 1'b0;
    push_buf(1'b0, 15'h0031, 3'd1, 32'h0000009A); exp_pops.push_back(1);
    exp_beat(1'b1, 15'h0030, 32'h00009A00, 4'b0010);
    wait_req(20, "t5_tmo_req");
    repeat (254) @(negedge clk);
    chk("t5_tmo_early", 64'(err), 64'd0);
    @(negedge clk);
    chk("t5_tmo_err", {62'h0, err, mem_req}, 64'd3);
    repeat (20) @(negedge clk);
    chk("t5_req_waits", {62'h0, err, mem_req}, 64'd3);
    ack_en = 1'b1;
    wait_drain(40, "t5_tmo_drain");

    // reset during the second beat aborts without popping; stray ack ignored
    ack_delay = 0;
    push_buf(1'b1, 15'h0043, 3'd6, 32'h0000BEEF);
    exp_beat(1'b0, 15'h0040, 32'hEF000000, 4'b1000);
    wait_req(20, "t6_req");
    ack_en = 1'b0;
    chk("t6_err_size", 64'(err), 64'd1);
    repeat (2) @(negedge clk);
    chk("t6_beat1", {12'h0, dc_req, dc_addr, dc_wdata, dc_be},
                    {12'h0, 1'b1, 15'h0044, 32'h000000BE, 4'b0111});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst", {60'h0, dc_req, mem_req, wb_read, err}, 64'd0);
    hold = 1'b1;
    rst = 1'b0;
    stray_dc = 1'b1;
    any = 1'b0;
    repeat (3) begin @(negedge clk); any |= dc_req | mem_req | wb_read; end
    stray_dc = 1'b0;
    chk("t6_stray_ack", 64'(any), 64'd0);
    chk("t6_beat0_done", 64'(exp_beats.size()), 64'd0);
    exp_pops.push_back(2);
    exp_beat(1'b0, 15'h0040, 32'hEF000000, 4'b1000);
    exp_beat(1'b0, 15'h0044, 32'h000000BE, 4'b0111);
    ack_en = 1'b1;
    hold = 1'b0;
    wait_drain(40, "t6_drain");

    // hold with an empty buffer still reports drained
    hold = 1'b1;
    repeat (3) @(negedge clk);
    chk("end_hold_idle", 64'(drain_idle), 64'd1);
    chk("end_queues", {32'(exp_beats.size()), 32'(exp_pops.size())}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
